// File: rtl/hit_detector.sv
`default_nettype none
// ============================================================================
// Module  : hit_detector
// Brief   : Hysteresis strike detector with peak tracking, hold-off and a
//           single-slot AXI-Stream event output with sticky drop flag.
// Revision: 1.0
// ============================================================================
module hit_detector #(
  parameter int MAG_WIDTH  = 24,
  parameter int SEQ_WIDTH  = 8,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [MAG_WIDTH-1:0]           magnitude_tdata,
  input  logic                           magnitude_tvalid,
  input  logic [MAG_WIDTH-1:0]           cfg_threshold_on,
  input  logic [MAG_WIDTH-1:0]           cfg_threshold_off,
  input  logic [HOLD_WIDTH-1:0]          cfg_holdoff,
  output logic [SEQ_WIDTH+MAG_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           active,
  output logic                           overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [MAG_WIDTH-1:0]           peak_q, peak_d;
  logic [SEQ_WIDTH-1:0]           seq_q, seq_d;
  logic [HOLD_WIDTH-1:0]          hold_q, hold_d;
  logic [SEQ_WIDTH+MAG_WIDTH-1:0] tdata_q, tdata_d;
  logic                           tvalid_q, tvalid_d;
  logic                           active_q, active_d;
  logic                           overflow_q, overflow_d;
  logic                           event_fire;
  logic                           slot_free;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      peak_q     <= '0;
      seq_q      <= '0;
      hold_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      active_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      seq_q      <= seq_d;
      hold_q     <= hold_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      active_q   <= active_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    seq_d      = seq_q;
    hold_d     = hold_q;
    event_fire = 1'b0;

    if (magnitude_tvalid) begin
      unique case (state_q)
        IDLE: begin
          if (magnitude_tdata >= cfg_threshold_on) begin
            state_d = ATTACK;
            peak_d  = magnitude_tdata;
          end
        end
        ATTACK: begin
          if (magnitude_tdata < cfg_threshold_off) begin
            // The ending sample is deliberately excluded from the peak.
            event_fire = 1'b1;
            seq_d      = SEQ_WIDTH'(seq_q + 1'b1);
            if (cfg_holdoff == '0) begin
              state_d = IDLE;
            end else begin
              hold_d  = cfg_holdoff;
              state_d = HOLDOFF;
            end
          end else if (magnitude_tdata > peak_q) begin
            peak_d = magnitude_tdata;
          end
        end
        HOLDOFF: begin
          hold_d = HOLD_WIDTH'(hold_q - 1'b1);
          if (hold_q <= HOLD_WIDTH'(1)) begin
            hold_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A held event may be replaced in the same cycle it is accepted.
  assign slot_free = !tvalid_q || m_axis_tready;

  always_comb begin
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    overflow_d = overflow_q;
    active_d   = (state_d == ATTACK);

    if (event_fire && slot_free) begin
      tvalid_d = 1'b1;
      tdata_d  = {seq_q, peak_q};
    end else begin
      if (event_fire) begin
        overflow_d = 1'b1;
      end
      if (tvalid_q && m_axis_tready) begin
        tvalid_d = 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign active        = active_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_hit_detector
// Brief   : Self-checking bench for hit_detector (vector table + scoreboard).
// Revision: 1.0
// ============================================================================
module tb_hit_detector;

  logic        aclk;
  logic        areset;
  logic [23:0] magnitude_tdata;
  logic        magnitude_tvalid;
  logic [23:0] cfg_threshold_on;
  logic [23:0] cfg_threshold_off;
  logic [15:0] cfg_holdoff;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        active;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [23:0] mag;
    logic        vld;
    logic        rdy;
    logic [15:0] hold;
    logic        act;
    logic        tv;
    logic        ov;
    logic        push;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  hit_detector #(
    .MAG_WIDTH (24),
    .SEQ_WIDTH (8),
    .HOLD_WIDTH(16)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .magnitude_tdata  (magnitude_tdata),
    .magnitude_tvalid (magnitude_tvalid),
    .cfg_threshold_on (cfg_threshold_on),
    .cfg_threshold_off(cfg_threshold_off),
    .cfg_holdoff      (cfg_holdoff),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .active           (active),
    .overflow         (overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; handshakes are observed
  // on the falling edge, where tvalid/tready hold their values for the next edge.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", m_axis_tdata, 32'hFFFF_FFFF);
      end else begin
        chk("event_tdata", m_axis_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [23:0] mag, input logic vld, input logic rdy);
    magnitude_tdata  = mag;
    magnitude_tvalid = vld;
    m_axis_tready    = rdy;
    @(posedge aclk);
    #1;
  endtask

  task automatic add(input logic [23:0] mag, input logic vld, input logic rdy,
                     input logic [15:0] hold, input logic act, input logic tv,
                     input logic ov, input logic push, input logic [31:0] data);
    vec_t r;
    r.mag = mag; r.vld = vld; r.rdy = rdy; r.hold = hold;
    r.act = act; r.tv = tv; r.ov = ov; r.push = push; r.data = data;
    tbl.push_back(r);
  endtask

  task automatic zeros(input int n, input logic rdy, input logic tv, input logic ov,
                       input logic [31:0] data);
    for (int k = 0; k < n; k++) add(24'd0, 1'b1, rdy, 16'd4, 1'b0, tv, ov, 1'b0, data);
  endtask

  task automatic do_reset();
    magnitude_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    magnitude_tdata   = '0;
    magnitude_tvalid  = 1'b0;
    m_axis_tready     = 1'b1;
    cfg_threshold_on  = 24'd1000;
    cfg_threshold_off = 24'd500;
    cfg_holdoff       = 16'd4;
    areset            = 1'b1;
    #2;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    do_reset();
    for (int k = 0; k < 3; k++) step(24'd0, 1'b0, 1'b1);
    chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Single strike, then hold-off with a gap
    add(24'd100,  1, 1, 4, 0, 0, 0, 0, 0);
    add(24'd1200, 1, 1, 4, 1, 0, 0, 0, 0);
    add(24'd3000, 1, 1, 4, 1, 0, 0, 0, 0);
    add(24'd2500, 1, 1, 4, 1, 0, 0, 0, 0);
    add(24'd400,  1, 1, 4, 0, 1, 0, 1, {8'd0, 24'd3000});
    add(24'd2000, 1, 1, 4, 0, 0, 0, 0, 0);
    add(24'd2000, 0, 1, 4, 0, 0, 0, 0, 0);
    add(24'd2000, 1, 1, 4, 0, 0, 0, 0, 0);
    add(24'd2000, 1, 1, 4, 0, 0, 0, 0, 0);
    add(24'd2000, 1, 1, 4, 0, 0, 0, 0, 0);
    add(24'd2000, 1, 1, 4, 1, 0, 0, 0, 0);
    add(24'd0,    1, 1, 4, 0, 1, 0, 1, {8'd1, 24'd2000});
    zeros(4, 1, 0, 0, 0);
    // Threshold boundaries
    add(24'd999,  1, 1, 4, 0, 0, 0, 0, 0);
    add(24'd1000, 1, 1, 4, 1, 0, 0, 0, 0);
    add(24'd500,  1, 1, 4, 1, 0, 0, 0, 0);
    add(24'd499,  1, 1, 4, 0, 1, 0, 1, {8'd2, 24'd1000});
    zeros(4, 1, 0, 0, 0);
    // Zero hold-off: immediate retrigger
    add(24'd999,  1, 1, 0, 0, 0, 0, 0, 0);
    add(24'd1000, 1, 1, 0, 1, 0, 0, 0, 0);
    add(24'd500,  1, 1, 0, 1, 0, 0, 0, 0);
    add(24'd499,  1, 1, 0, 0, 1, 0, 1, {8'd3, 24'd1000});
    add(24'd1000, 1, 1, 0, 1, 0, 0, 0, 0);
    add(24'd0,    1, 1, 0, 0, 1, 0, 1, {8'd4, 24'd1000});
    add(24'd0,    0, 1, 4, 0, 0, 0, 0, 0);
    // Backpressure: held event, dropped event, sticky overflow
    add(24'd1500, 1, 0, 4, 1, 0, 0, 0, 0);
    add(24'd400,  1, 0, 4, 0, 1, 0, 1, {8'd5, 24'd1500});
    zeros(4, 0, 1, 0, {8'd5, 24'd1500});
    add(24'd2600, 1, 0, 4, 1, 1, 0, 0, {8'd5, 24'd1500});
    add(24'd100,  1, 0, 4, 0, 1, 1, 0, {8'd5, 24'd1500});
    zeros(4, 0, 1, 1, {8'd5, 24'd1500});
    add(24'd0,    0, 1, 4, 0, 0, 1, 0, 0);
    add(24'd3000, 1, 1, 4, 1, 0, 1, 0, 0);
    add(24'd0,    1, 1, 4, 0, 1, 1, 1, {8'd7, 24'd3000});
    zeros(4, 0, 1, 1, {8'd7, 24'd3000});
    add(24'd1200, 1, 0, 4, 1, 1, 1, 0, {8'd7, 24'd3000});
    add(24'd0,    1, 1, 4, 0, 1, 1, 1, {8'd8, 24'd1200});
    add(24'd0,    0, 1, 4, 0, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cfg_holdoff = tbl[i].hold;
      if (tbl[i].push) exp_q.push_back(tbl[i].data);
      step(tbl[i].mag, tbl[i].vld, tbl[i].rdy);
      chk($sformatf("row%0d_active", i), 32'(active), 32'(tbl[i].act));
      chk($sformatf("row%0d_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].tv));
      chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
      if (tbl[i].tv) chk($sformatf("row%0d_tdata", i), m_axis_tdata, tbl[i].data);
    end

    // Asynchronous reset mid-strike with an event held and overflow set
    cfg_holdoff = 16'd4;
    for (int k = 0; k < 4; k++) step(24'd0, 1'b1, 1'b1);
    step(24'd1200, 1'b1, 1'b0);
    step(24'd0,    1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(24'd0, 1'b1, 1'b0);
    step(24'd1200, 1'b1, 1'b0);
    step(24'd3000, 1'b1, 1'b0);
    chk("pre_rst_active", 32'(active), 32'd1);
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    chk("async_rst_active", 32'(active), 32'd0);
    chk("async_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("async_rst_tdata", m_axis_tdata, 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    step(24'd400, 1'b1, 1'b1);
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("post_rst_active", 32'(active), 32'd0);
    exp_q.push_back({8'd0, 24'd1200});
    step(24'd1200, 1'b1, 1'b1);
    step(24'd0,    1'b1, 1'b1);
    chk("post_rst_event_tvalid", 32'(m_axis_tvalid), 32'd1);
    for (int k = 0; k < 4; k++) step(24'd0, 1'b1, 1'b1);

    // Sequence wrap: 257 strikes after reset, the last reports seq 0
    do_reset();
    cfg_holdoff = 16'd0;
    for (int i = 0; i < 257; i++) begin
      logic [7:0]  s;
      logic [23:0] pk;
      s  = 8'(i);
      pk = 24'(1000 + i);
      exp_q.push_back({s, pk});
      step(pk, 1'b1, 1'b1);
      step(24'd0, 1'b1, 1'b1);
    end
    chk("wrap_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("wrap_seq", 32'(m_axis_tdata[31:24]), 32'd0);
    for (int k = 0; k < 3; k++) step(24'd0, 1'b0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hit_detector.md
# hit_detector

Downstream stage of the per-corner `channel` block. Consumes its unsigned magnitude stream, detects drum-stick strikes with hysteresis thresholds, tracks the peak magnitude of each strike and enforces a re-trigger hold-off. Emits one AXI-Stream event per strike (peak plus sequence number) toward the host/event FIFO. Flags dropped events under backpressure.

## Interface
- `MAG_WIDTH`, 24: width of magnitude samples and thresholds.
- `SEQ_WIDTH`, 8: width of the event sequence counter.
- `HOLD_WIDTH`, 16: width of the hold-off counter.
- `aclk`  in  1  single clock; all logic on rising edge.
- `areset`  in  1  reset, asynchronous and active-high.
- `magnitude_tdata`  in  MAG_WIDTH  unsigned magnitude from `channel`.
- `magnitude_tvalid`  in  1  sample qualifier; no ready (source cannot stall).
- `cfg_threshold_on`  in  MAG_WIDTH  strike start threshold (mag >= on).
- `cfg_threshold_off`  in  MAG_WIDTH  strike end threshold (mag < off).
- `cfg_holdoff`  in  HOLD_WIDTH  valid samples ignored after a strike ends.
- `m_axis_tdata`  out  SEQ_WIDTH+MAG_WIDTH  {seq, peak}.
- `m_axis_tvalid`  out  1  event valid.
- `m_axis_tready`  in  1  event accepted.
- `active`  out  1  high while in ATTACK.
- `overflow`  out  1  sticky; set when an event is dropped.

## Operation
- Samples with `magnitude_tvalid`=0 are ignored in every state; state, counters and peak are unchanged.
- Comparisons are unsigned. Config is static during operation; `cfg_threshold_off` <= `cfg_threshold_on` is required of software. If violated, behaviour follows the rules below literally.
- IDLE: on a valid sample with mag >= on, go to ATTACK and load peak <= mag.
- ATTACK, on a valid sample with mag < off:
  - Strike ends. Emit event {seq, peak}; this sample is not included in peak.
  - seq <= seq+1, wrapping modulo 2^SEQ_WIDTH. seq increments on every detected strike, including dropped ones, so gaps reveal drops.
  - If `cfg_holdoff`=0, go to IDLE; else load hold counter <= `cfg_holdoff` and go to HOLDOFF.
- ATTACK, on a valid sample with mag >= off: peak <= max(peak, mag). No limit on strike length.
- HOLDOFF: each valid sample decrements the counter and is otherwise ignored. The sample that decrements 1 to 0 moves the state to IDLE. The next valid sample is evaluated in IDLE.
- Output slot, one register:
  - Event loads if the slot is free, or if `m_axis_tvalid`&&`m_axis_tready` in the same cycle (simultaneous accept and load is allowed, with no bubble).
  - Otherwise the new event is dropped, `overflow` <= 1, and the held event is unchanged.
- `m_axis_tdata` is stable while `m_axis_tvalid`=1 and `m_axis_tready`=0. `m_axis_tvalid` deasserts after acceptance unless a new event loads that same cycle.
- `overflow` clears only on reset.

## Timing
- Reset (async assert, release sync to `aclk`):
  - state IDLE, peak 0, seq 0, hold counter 0.
  - `m_axis_tvalid` 0, `m_axis_tdata` 0, `active` 0, `overflow` 0.
- Reset mid-strike discards the strike; no event is emitted.
- Latency: `m_axis_tvalid` rises on the first clock edge after the cycle in which the ending sample is presented (1 cycle).
- `active` is registered. It goes high the cycle after the triggering sample and low the cycle after the ending sample.
- The block accepts one sample per cycle at full rate indefinitely.
- Hold-off is counted in valid samples, not clocks.

## Test plan
Common settings: on=1000, off=500, holdoff=4, `m_axis_tready`=1 unless stated.
- Reset: assert `areset` asynchronously mid-cycle. Required: all outputs 0 immediately. After release with no samples, `m_axis_tvalid` stays 0.
- Single strike: samples 100, 1200, 3000, 2500, 400 on consecutive cycles. Required: exactly one event with tdata={8'd0, 24'd3000}, valid 1 cycle after the 400 sample. `active` is high for 3 cycles.
- Hold-off and gaps: strike as above, then 2000, gap (tvalid=0), 2000, 2000, 2000, then 2000. Required: the first four valid 2000s are ignored. The fifth valid 2000 re-enters ATTACK. Ending it with 0 yields tdata={8'd1, 24'd2000}.
- Boundaries: sample 999 (no trigger), 1000 (trigger), 500 (still ATTACK), 499 (end). Required: event peak=1000. Repeat with holdoff=0: the next sample 1000 retriggers immediately.
- Backpressure: `m_axis_tready`=0, two complete strikes with peaks 1500 and 2600. Required:
  - The first event {0, 1500} is held stable.
  - The second is dropped and `overflow` goes to 1.
  - Raise tready: {0, 1500} is accepted.
  - The next strike delivers seq=2.
  - Tready high on the same cycle as the next load: no bubble.
- Reset mid-ATTACK: samples 1200, 3000, then assert `areset`, then 400. Required: no event. seq is 0 after release and the next strike reports seq 0.
- Seq wrap: 256 strikes. Required: the 257th event carries seq 0.
